mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several clock cycles.
- Drives every datapath control: PC, IR, immediate extender, ALU, register file and data memory.
- Decodes op/funct from the latched IR and replaces the single-cycle combinational controller.

Parameters:
- None. Encodings below are fixed.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  IR[31:26] from the latched instruction register.
- funct  input  6  IR[5:0].
- zero  input  1  ALU result == 0.
- PCWr  output  1  PC write enable.
- PCSrc  output  2  00 = PC+4, 01 = branch target, 10 = jump target {PC[31:28], IR[25:0], 00}, 11 = GPR[rs].
- IRWr  output  1  IR write enable.
- EXTOp  output  2  00 = zero-extend, 01 = sign-extend, 10 = imm<<16.
- ALUSrcB  output  1  0 = GPR[rt], 1 = extended immediate.
- ALUOp  output  3  000 = add, 001 = sub, 010 = or.
- RegWrite  output  1  GPR write enable.
- RegDst  output  2  00 = rt, 01 = rd, 10 = $31.
- WDSel  output  2  00 = ALU result register, 01 = memory data register, 10 = PC (already PC+4).
- MemWrite  output  1  data memory write enable.
- state  output  3  current state, for debug.

Behaviour:
- States: FETCH = 0, DECODE = 1, EXE = 2, MEM = 3, WB = 4. A single state register updates on the clk rising edge.
- Reset: when reset = 1 at a clock edge, state <= FETCH. While reset is high, PCWr, IRWr, RegWrite and MemWrite are forced to 0.
- Output decode: all outputs are combinational from state, op, funct and zero. op and funct come from IR, which is stable outside FETCH. Every output not listed for a state is 0.
- Supported instructions:
  - addu: op 000000, funct 100001.
  - subu: op 000000, funct 100011.
  - jr: op 000000, funct 001000.
  - ori: op 001101.
  - lui: op 001111.
  - lw: op 100011.
  - sw: op 101011.
  - beq: op 000100.
  - j: op 000010.
  - jal: op 000011.
- FETCH:
  - Outputs: IRWr = 1, PCWr = 1, PCSrc = 00.
  - Next state: DECODE.
- DECODE:
  - j: PCWr = 1, PCSrc = 10; next FETCH.
  - jal: as j, plus RegWrite = 1, RegDst = 10, WDSel = 10; next FETCH.
  - jr: PCWr = 1, PCSrc = 11; next FETCH.
  - Unsupported op/funct: no enables, executes as a nop; next FETCH.
  - All other supported instructions: next EXE.
- EXE:
  - addu / subu: ALUSrcB = 0, ALUOp = add / sub; next WB.
  - ori: EXTOp = 00, ALUSrcB = 1, ALUOp = or; next WB.
  - lui: EXTOp = 10, ALUSrcB = 1, ALUOp = or (rs = $0); next WB.
  - lw / sw: EXTOp = 01, ALUSrcB = 1, ALUOp = add; next MEM.
  - beq: ALUSrcB = 0, ALUOp = sub, EXTOp = 01. If zero = 1, PCWr = 1 and PCSrc = 01. Next FETCH.
- MEM:
  - sw: MemWrite = 1; next FETCH.
  - lw: no enables; next WB.
- WB:
  - Common: RegWrite = 1; next FETCH.
  - R-type: RegDst = 01, WDSel = 00.
  - ori / lui: RegDst = 00, WDSel = 00.
  - lw: RegDst = 00, WDSel = 01.
- Cycles per instruction (CPI):
  - j, jal, jr, unsupported: 2.
  - beq: 3.
  - sw: 4.
  - addu, subu, ori, lui: 4.
  - lw: 5.
- Illegal state values 5–7: all enables 0; next FETCH.
- Reset asserted mid-instruction: the instruction is abandoned, and no write enable is asserted in that cycle. The first cycle after reset deasserts is FETCH.
- zero is sampled only in EXE for beq and ignored everywhere else.

Test Plan:
- Reset held 2 cycles, then addu (op 0, funct 0x21) → state sequence 0,1,2,4,0. RegWrite = 1 only in WB with RegDst = 01. No enables during reset.
- lw → states 0,1,2,3,4. EXTOp = 01 and ALUSrcB = 1 in EXE; WB has WDSel = 01, RegDst = 00. sw → 0,1,2,3,0 with MemWrite = 1 only in MEM.
- beq with zero = 1 → EXE asserts PCWr = 1, PCSrc = 01, ALUOp = 001. beq with zero = 0 → PCWr = 0 in EXE; both return to FETCH after 3 cycles.
- jal → 2 cycles. DECODE asserts PCWr = 1, PCSrc = 10, RegWrite = 1, RegDst = 10, WDSel = 10. jr → PCSrc = 11.
- lui → EXE has EXTOp = 10, ALUOp = 010. ori → EXE has EXTOp = 00. Unsupported op 0x3F → 2-cycle nop with no enables after FETCH.
- reset asserted while in MEM for sw → MemWrite = 0 that cycle, state = 0 at the next edge, and the following cycle is a normal FETCH.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS datapath.
// One state register; every control output is decoded from state, op, funct and zero.
module mc_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       PCWr,
   output logic [1:0] PCSrc,
   output logic       IRWr,
   output logic [1:0] EXTOp,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] WDSel,
   output logic       MemWrite,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXE    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t st, nxt;

   logic rtype, addu, subu, jr, ori, lui, lw, sw, beq, j, jal;
   logic alu_rr, alu_imm;

   assign rtype = (op == 6'b000000);
   assign addu  = rtype && (funct == 6'b100001);
   assign subu  = rtype && (funct == 6'b100011);
   assign jr    = rtype && (funct == 6'b001000);
   assign ori   = (op == 6'b001101);
   assign lui   = (op == 6'b001111);
   assign lw    = (op == 6'b100011);
   assign sw    = (op == 6'b101011);
   assign beq   = (op == 6'b000100);
   assign j     = (op == 6'b000010);
   assign jal   = (op == 6'b000011);

   assign alu_rr  = addu || subu;
   assign alu_imm = ori || lui;

   always_ff @(posedge clk) begin
      if (reset) st <= FETCH;
      else       st <= nxt;
   end

   always_comb begin
      nxt      = FETCH;
      PCWr     = 1'b0;
      PCSrc    = 2'b00;
      IRWr     = 1'b0;
      EXTOp    = 2'b00;
      ALUSrcB  = 1'b0;
      ALUOp    = 3'b000;
      RegWrite = 1'b0;
      RegDst   = 2'b00;
      WDSel    = 2'b00;
      MemWrite = 1'b0;
      case (st)
         FETCH: begin
            IRWr = 1'b1;
            PCWr = 1'b1;
            nxt  = DECODE;
         end
         DECODE: begin
            if (j || jal) begin
               PCWr  = 1'b1;
               PCSrc = 2'b10;
               if (jal) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'b10;
                  WDSel    = 2'b10;
               end
            end else if (jr) begin
               PCWr  = 1'b1;
               PCSrc = 2'b11;
            end else if (alu_rr || alu_imm || lw || sw || beq) begin
               nxt = EXE;
            end
         end
         EXE: begin
            if (alu_rr) begin
               ALUOp = subu ? 3'b001 : 3'b000;
               nxt   = WB;
            end else if (alu_imm) begin
               EXTOp   = lui ? 2'b10 : 2'b00;
               ALUSrcB = 1'b1;
               ALUOp   = 3'b010;
               nxt     = WB;
            end else if (lw || sw) begin
               EXTOp   = 2'b01;
               ALUSrcB = 1'b1;
               nxt     = MEM;
            end else if (beq) begin
               EXTOp = 2'b01;
               ALUOp = 3'b001;
               if (zero) begin
                  PCWr  = 1'b1;
                  PCSrc = 2'b01;
               end
            end
         end
         MEM: begin
            if (sw)      MemWrite = 1'b1;
            else if (lw) nxt      = WB;
         end
         WB: begin
            RegWrite = 1'b1;
            if (rtype) RegDst = 2'b01;
            if (lw)    WDSel  = 2'b01;
         end
         default: nxt = FETCH;
      endcase
      // an instruction caught by reset must not commit anything
      if (reset) begin
         PCWr     = 1'b0;
         IRWr     = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

   assign state = st;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and random instruction streams for mc_ctrl,
// checked against a per-instruction cycle-script model.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       PCWr, IRWr, ALUSrcB, RegWrite, MemWrite;
   logic [1:0] PCSrc, EXTOp, RegDst, WDSel;
   logic [2:0] ALUOp, state;

   typedef struct packed {
      logic [2:0] st;
      logic       pcwr;
      logic [1:0] pcsrc;
      logic       irwr;
      logic [1:0] extop;
      logic       alusrcb;
      logic [2:0] aluop;
      logic       regwr;
      logic [1:0] regdst;
      logic [1:0] wdsel;
      logic       memwr;
   } ctl_t;

   ctl_t obs;
   ctl_t exq[$];
   logic zq[$];
   int   nchk = 0;
   int   nfail = 0;

   mc_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .EXTOp(EXTOp),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
      .RegDst(RegDst), .WDSel(WDSel), .MemWrite(MemWrite), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, PCWr, PCSrc, IRWr, EXTOp, ALUSrcB, ALUOp,
                 RegWrite, RegDst, WDSel, MemWrite};

   function automatic ctl_t rec(input int s, pw, ps, iw, ex, sb, ao,
                                rw, rd, wd, mw);
      ctl_t r;
      r.st = 3'(s);      r.pcwr = 1'(pw);   r.pcsrc = 2'(ps);
      r.irwr = 1'(iw);   r.extop = 2'(ex);  r.alusrcb = 1'(sb);
      r.aluop = 3'(ao);  r.regwr = 1'(rw);  r.regdst = 2'(rd);
      r.wdsel = 2'(wd);  r.memwr = 1'(mw);
      return r;
   endfunction

   function automatic string name_of(input logic [5:0] o, f);
      case (o)
         6'h00: case (f)
                   6'h21:   return "addu";
                   6'h23:   return "subu";
                   6'h08:   return "jr";
                   default: return "nop";
                endcase
         6'h0D:   return "ori";
         6'h0F:   return "lui";
         6'h23:   return "lw";
         6'h2B:   return "sw";
         6'h04:   return "beq";
         6'h02:   return "j";
         6'h03:   return "jal";
         default: return "nop";
      endcase
   endfunction

   // expected cycle script for one instruction, fetch to last cycle
   function automatic void build(input logic [5:0] o, f, input logic z);
      string n = name_of(o, f);
      exq.delete();
      exq.push_back(rec(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      case (n)
         "j":     exq.push_back(rec(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
         "jal":   exq.push_back(rec(1, 1, 2, 0, 0, 0, 0, 1, 2, 2, 0));
         "jr":    exq.push_back(rec(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
         default: exq.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      endcase
      if (n != "j" && n != "jal" && n != "jr" && n != "nop") begin
         case (n)
            "addu": exq.push_back(rec(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            "subu": exq.push_back(rec(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
            "ori":  exq.push_back(rec(2, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
            "lui":  exq.push_back(rec(2, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0));
            "beq":  exq.push_back(rec(2, z, z, 0, 1, 0, 1, 0, 0, 0, 0));
            default: exq.push_back(rec(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
         endcase
         if (n == "sw")
            exq.push_back(rec(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
         if (n == "lw")
            exq.push_back(rec(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         if (n != "sw" && n != "beq")
            exq.push_back(rec(4, 0, 0, 0, 0, 0, 0, 1,
                              (n == "addu" || n == "subu") ? 1 : 0,
                              (n == "lw") ? 1 : 0, 0));
      end
      zq.delete();
      foreach (exq[i]) zq.push_back(1'($urandom_range(0, 1)));
      if (exq.size() > 2) zq[2] = z;
   endfunction

   task automatic check(input string tag, input int cyc, input ctl_t exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s cyc%0d obs=%h exp=%h", tag, cyc, obs, exp);
      end
   endtask

   // starts just after a falling edge with the DUT in FETCH
   task automatic run(input logic [5:0] o, f, input logic z,
                      input string tag, input int ncyc);
      build(o, f, z);
      op = o;
      funct = f;
      for (int i = 0; i < exq.size() && (ncyc < 0 || i < ncyc); i++) begin
         zero = zq[i];
         #1;
         check(tag, i, exq[i]);
         @(negedge clk);
      end
   endtask

   logic [5:0] pool_op [11] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23,
                                6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};
   logic [5:0] pool_fn [11] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

   initial begin
      reset = 1'b1;
      op = 6'h00;
      funct = 6'h00;
      zero = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         nchk++;
         assert ({PCWr, IRWr, RegWrite, MemWrite} === 4'b0) else begin
            nfail++;
            $error("FAIL rst_en obs=%b exp=0000",
                   {PCWr, IRWr, RegWrite, MemWrite});
         end
         nchk++;
         assert (state === 3'd0) else begin
            nfail++;
            $error("FAIL rst_state obs=%0d exp=0", state);
         end
      end
      reset = 1'b0;

      run(6'h00, 6'h21, 1'b0, "addu", -1);
      run(6'h23, 6'h00, 1'b1, "lw", -1);
      run(6'h2B, 6'h00, 1'b0, "sw", -1);
      run(6'h04, 6'h00, 1'b1, "beq_z1", -1);
      run(6'h04, 6'h00, 1'b0, "beq_z0", -1);
      run(6'h03, 6'h00, 1'b0, "jal", -1);
      run(6'h00, 6'h08, 1'b0, "jr", -1);
      run(6'h0F, 6'h00, 1'b0, "lui", -1);
      run(6'h0D, 6'h00, 1'b1, "ori", -1);
      run(6'h3F, 6'h00, 1'b0, "nop3f", -1);
      run(6'h00, 6'h23, 1'b0, "subu", -1);
      run(6'h02, 6'h00, 1'b0, "j", -1);
      run(6'h00, 6'h2A, 1'b0, "nop_rt", -1);

      // sw interrupted by reset in its MEM cycle
      run(6'h2B, 6'h00, 1'b0, "sw_rst", 3);
      reset = 1'b1;
      #1;
      nchk++;
      assert (state === 3'd3 && {PCWr, IRWr, RegWrite, MemWrite} === 4'b0)
      else begin
         nfail++;
         $error("FAIL mem_rst obs=%0d/%b exp=3/0000", state,
                {PCWr, IRWr, RegWrite, MemWrite});
      end
      @(negedge clk);
      nchk++;
      assert (state === 3'd0) else begin
         nfail++;
         $error("FAIL mem_rst_state obs=%0d exp=0", state);
      end
      reset = 1'b0;
      run(6'h00, 6'h21, 1'b1, "after_rst", -1);

      for (int k = 0; k < 40; k++) begin
         int idx = $urandom_range(0, 11);
         if (idx == 11)
            run(6'($urandom), 6'($urandom), 1'($urandom), "rnd_any", -1);
         else
            run(pool_op[idx], pool_fn[idx], 1'($urandom), "rnd", -1);
      end

      #1;
      nchk++;
      assert (state === 3'd0) else begin
         nfail++;
         $error("FAIL end_state obs=%0d exp=0", state);
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
